hazard_unit: RTL and testbench

//  Pipeline hazard stage beside the 5-stage ARM controller; sole producer of FlushE, consumer of its E/M/W

---
 rtl/hazard_unit_pkg.sv | 12 +
 rtl/hazard_fwd_sel.sv | 31 +++
 rtl/hazard_unit.sv | 154 +++++++++++++++
 tb/tb_hazard_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the hazard stage: forwarding selects and the PC register address.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  localparam logic [3:0] REG_PC = 4'hF;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one Execute operand; Memory beats Writeback, R15 is never forwarded.
import hazard_unit_pkg::*;

module hazard_fwd_sel #(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] rae,
  input  logic [REG_AW-1:0] wa3m,
  input  logic [REG_AW-1:0] wa3w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output logic [1:0]        forward
);

  logic not_pc;

  assign not_pc = (rae != REG_AW'(REG_PC));

  // priority select between M and W result buses
  always_comb begin
    forward = FWD_RF;
    if (reg_write_m && (rae == wa3m) && not_pc) begin
      forward = FWD_M;
    end else if (reg_write_w && (rae == wa3w) && not_pc) begin
      forward = FWD_W;
    end else begin
      forward = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard stage: forwarding, load-use stall, PC-write tracking and flushes.
// Optional HAZARD_PERF_EN adds saturating StallCnt/FlushCnt performance counters.
import hazard_unit_pkg::*;

module hazard_unit #(
  parameter int REG_AW = 4
`ifdef HAZARD_PERF_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] RA1E,
  input  logic [REG_AW-1:0] RA2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              PCSD,
  input  logic              PCSrcE,
  input  logic              PCSrcW,
  input  logic              BranchTakenE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt,
`endif
  output logic              PCWrPendingF
);

  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;
  logic       ldr_stall_s;
  logic       pc_pend_s;
  logic       pend_e_d, pend_e_q;
  logic       pend_m_d, pend_m_q;

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rae         (RA1E),
    .wa3m        (WA3M),
    .wa3w        (WA3W),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .forward     (fwd_a_s)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rae         (RA2E),
    .wa3m        (WA3M),
    .wa3w        (WA3W),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .forward     (fwd_b_s)
  );

  assign ldr_stall_s = MemtoRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));
  assign pc_pend_s   = PCSD | pend_e_q | pend_m_q;

  // output decode; reset forces a bubble into D and E with nothing forwarded
  always_comb begin
    ForwardAE    = FWD_RF;
    ForwardBE    = FWD_RF;
    StallF       = 1'b0;
    StallD       = 1'b0;
    FlushD       = 1'b1;
    FlushE       = 1'b1;
    PCWrPendingF = 1'b0;
    if (reset) begin
      ForwardAE    = FWD_RF;
      ForwardBE    = FWD_RF;
      StallF       = 1'b0;
      StallD       = 1'b0;
      FlushD       = 1'b1;
      FlushE       = 1'b1;
      PCWrPendingF = 1'b0;
    end else begin
      ForwardAE    = fwd_a_s;
      ForwardBE    = fwd_b_s;
      StallF       = ldr_stall_s | pc_pend_s;
      StallD       = ldr_stall_s;
      FlushD       = pc_pend_s | PCSrcW | BranchTakenE;
      FlushE       = ldr_stall_s | BranchTakenE;
      PCWrPendingF = pc_pend_s;
    end
  end

  // tracker next state; a flushed E never carries the PC write, so it is re-presented from D
  always_comb begin
    pend_e_d = 1'b0;
    pend_m_d = 1'b0;
    if (reset) begin
      pend_e_d = 1'b0;
      pend_m_d = 1'b0;
    end else begin
      pend_e_d = FlushE ? 1'b0 : PCSD;
      pend_m_d = PCSrcE;
    end
  end

  // tracker state register
  always_ff @(posedge clk) begin
    pend_e_q <= pend_e_d;
    pend_m_q <= pend_m_d;
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  // saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (reset) begin
      stall_cnt_d = {CNT_W{1'b0}};
      flush_cnt_d = {CNT_W{1'b0}};
    end else begin
      if (StallD && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (FlushE && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end
  end

  // counter registers
  always_ff @(posedge clk) begin
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  // performance counters not built
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (perf-counter test only with HAZARD_PERF_EN).
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSD, PCSrcE, PCSrcW, BranchTakenE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, FlushD, FlushE, PCWrPendingF;
`ifdef HAZARD_PERF_EN
  logic [1:0] StallCnt, FlushCnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

`ifdef HAZARD_PERF_EN
  hazard_unit #(.REG_AW(4), .CNT_W(2)) dut (
`else
  hazard_unit #(.REG_AW(4)) dut (
`endif
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSD(PCSD), .PCSrcE(PCSrcE), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
`ifdef HAZARD_PERF_EN
    .StallCnt(StallCnt), .FlushCnt(FlushCnt),
`endif
    .PCWrPendingF(PCWrPendingF)
  );

  task automatic clear_inputs();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd1; WA3M = 4'd1; WA3W = 4'd1;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    PCSD = 1'b0; PCSrcE = 1'b0; PCSrcW = 1'b0; BranchTakenE = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1;
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd0;
    tick();
    checks++; if (ForwardAE !== 2'b00) begin failures++; $display("FAIL reset_fwd_a: got %b expected 00", ForwardAE); end
    checks++; if ({StallF, StallD} !== 2'b00) begin failures++; $display("FAIL reset_stall: got %b expected 00", {StallF, StallD}); end
    checks++; if ({FlushD, FlushE} !== 2'b11) begin failures++; $display("FAIL reset_flush: got %b expected 11", {FlushD, FlushE}); end
    clear_inputs();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1;
    #1;
    checks++; if (ForwardAE !== 2'b10) begin failures++; $display("FAIL fwd_a_m_prio: got %b expected 10", ForwardAE); end
    RegWriteM = 1'b0;
    #1;
    checks++; if (ForwardAE !== 2'b01) begin failures++; $display("FAIL fwd_a_w: got %b expected 01", ForwardAE); end
    RA2E = 4'd9; WA3M = 4'd9; RegWriteM = 1'b1;
    #1;
    checks++; if (ForwardBE !== 2'b10) begin failures++; $display("FAIL fwd_b_m: got %b expected 10", ForwardBE); end
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    #1;
    checks++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin failures++; $display("FAIL fwd_none: got %b expected 0000", {ForwardAE, ForwardBE}); end
    tick();
  endtask

  task automatic test_r15();
    clear_inputs();
    RA2E = 4'd15; WA3M = 4'd15; RegWriteM = 1'b1; WA3W = 4'd15; RegWriteW = 1'b1;
    #1;
    checks++; if (ForwardBE !== 2'b00) begin failures++; $display("FAIL fwd_b_r15: got %b expected 00", ForwardBE); end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd2;
    #1;
    checks++; if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin failures++; $display("FAIL ldr_stall: got %b expected 1110", {StallF, StallD, FlushE, FlushD}); end
    tick();
    clear_inputs();
    #1;
    checks++; if ({StallF, StallD, FlushE, FlushD} !== 4'b0000) begin failures++; $display("FAIL ldr_release: got %b expected 0000", {StallF, StallD, FlushE, FlushD}); end
    MemtoRegE = 1'b1; RegWriteE = 1'b0; WA3E = 4'd2; RA1D = 4'd2;
    #1;
    checks++; if (StallD !== 1'b0) begin failures++; $display("FAIL ldr_no_regwrite: got %b expected 0", StallD); end
    tick();
  endtask

  task automatic test_pc_write();
    clear_inputs();
    tick();
    PCSD = 1'b1;
    #1;
    checks++; if ({PCWrPendingF, StallF, FlushD} !== 3'b111) begin failures++; $display("FAIL pcw_d: got %b expected 111", {PCWrPendingF, StallF, FlushD}); end
    tick();
    PCSD = 1'b0; PCSrcE = 1'b1;
    #1;
    checks++; if (PCWrPendingF !== 1'b1) begin failures++; $display("FAIL pcw_e: got %b expected 1", PCWrPendingF); end
    tick();
    PCSrcE = 1'b0;
    #1;
    checks++; if (PCWrPendingF !== 1'b1) begin failures++; $display("FAIL pcw_m: got %b expected 1", PCWrPendingF); end
    tick();
    PCSrcW = 1'b1;
    #1;
    checks++; if ({PCWrPendingF, StallF, FlushD} !== 3'b001) begin failures++; $display("FAIL pcw_w: got %b expected 001", {PCWrPendingF, StallF, FlushD}); end
    tick();
    PCSrcW = 1'b0;
    #1;
    checks++; if ({PCWrPendingF, FlushD} !== 2'b00) begin failures++; $display("FAIL pcw_done: got %b expected 00", {PCWrPendingF, FlushD}); end
    tick();
  endtask

  task automatic test_branch_ldr();
    clear_inputs();
    tick();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd7; RA1D = 4'd7;
    BranchTakenE = 1'b1; PCSD = 1'b1;
    #1;
    checks++; if ({FlushD, FlushE, StallD} !== 3'b111) begin failures++; $display("FAIL br_ldr: got %b expected 111", {FlushD, FlushE, StallD}); end
    tick();
    clear_inputs();
    #1;
    checks++; if (PCWrPendingF !== 1'b0) begin failures++; $display("FAIL br_ldr_pend_e: got %b expected 0", PCWrPendingF); end
    tick();
  endtask

  task automatic test_reset_midflight();
    clear_inputs();
    PCSD = 1'b1; PCSrcE = 1'b1;
    tick();
    PCSD = 1'b0;
    reset = 1'b1;
    tick();
    PCSrcE = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if ({PCWrPendingF, StallF} !== 2'b00) begin failures++; $display("FAIL reset_midflight: got %b expected 00", {PCWrPendingF, StallF}); end
    tick();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (StallCnt !== 2'd0) begin failures++; $display("FAIL perf_init: got %0d expected 0", StallCnt); end
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd4; RA1D = 4'd4;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (StallCnt !== 2'd3) begin failures++; $display("FAIL perf_stall_sat: got %0d expected 3", StallCnt); end
    checks++; if (FlushCnt !== 2'd3) begin failures++; $display("FAIL perf_flush_sat: got %0d expected 3", FlushCnt); end
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({StallCnt, FlushCnt} !== 4'd0) begin failures++; $display("FAIL perf_reset: got %b expected 0000", {StallCnt, FlushCnt}); end
    tick();
  endtask
`endif

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick();
    test_reset();
    test_forwarding();
    test_r15();
    test_load_use();
    test_pc_write();
    test_branch_ldr();
    test_reset_midflight();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
